// File: rtl/div.sv
// 32-bit radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Returns {remainder, quotient} and stalls the execute stage while it works.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_op1_neg;
  logic        w_op2_neg;
  logic [32:0] w_shift;
  logic [31:0] w_sub;
  logic        w_take;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  assign w_op1_neg = signed_div_i & opdata1_i[31];
  assign w_op2_neg = signed_div_i & opdata2_i[31];

  // r_quo starts as the dividend magnitude and shifts quotient bits in from the right.
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_take   = (w_shift >= {1'b0, r_dvs});
  assign w_sub    = w_shift[31:0] - r_dvs;
  assign w_rem_nx = w_take ? w_sub : w_shift[31:0];
  assign w_quo_nx = {r_quo[30:0], w_take};

  assign stallreq_o = ~rst & (((r_state == FREE) & start_i & ~annul_i) |
                              (r_state == BYZERO) | (r_state == ON));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FREE;
      r_cnt    <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_dvs    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= 64'd0;
    end else begin
      case (r_state)
        FREE: begin
          if (start_i && !annul_i) begin
            r_quo   <= cond_neg(opdata1_i, w_op1_neg);
            r_dvs   <= cond_neg(opdata2_i, w_op2_neg);
            r_rem   <= 32'd0;
            r_cnt   <= 6'd0;
            r_neg_q <= w_op1_neg ^ w_op2_neg;
            r_neg_r <= w_op1_neg;
            r_state <= (opdata2_i == 32'd0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          if (annul_i) begin
            r_state <= FREE;
          end else begin
            r_state  <= END;
            ready_o  <= 1'b1;
            result_o <= 64'd0;
          end
        end
        ON: begin
          if (annul_i) begin
            r_state <= FREE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 6'd1;
            // The 32nd iteration publishes its sign-corrected result directly.
            if (r_cnt == 6'd31) begin
              r_state  <= END;
              ready_o  <= 1'b1;
              result_o <= {cond_neg(w_rem_nx, r_neg_r), cond_neg(w_quo_nx, r_neg_q)};
            end
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            r_state  <= FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: begin
          r_state  <= FREE;
          ready_o  <= 1'b0;
          result_o <= 64'd0;
        end
      endcase
    end
  end

endmodule
